// File: rtl/snow3g_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snow3g_ctrl: SNOW 3G session sequencer (load, 32 init rounds, discard, |
// | then keystream generation with valid/ready output).                    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module snow3g_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic [15:0]  num_words,
  input  logic [31:0]  f_word,
  input  logic [31:0]  lfsr_s0,
  output logic [511:0] lfsr_init,
  output logic         lfsr_load,
  output logic         lfsr_step,
  output logic         lfsr_init_mode,
  output logic         fsm_clear,
  output logic         fsm_step,
  output logic [31:0]  ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         busy,
  output logic         done,
  output logic [15:0]  words_left
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_INIT    = 3'd2,
    S_DISCARD = 3'd3,
    S_GEN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [31:0] c_ones = 32'hFFFF_FFFF;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [127:0]  r_key;
  logic [127:0]  r_iv;
  logic [15:0]   r_num_words;
  logic [15:0]   r_words_left;
  logic [4:0]    r_init_cnt;
  logic [31:0]   r_ks_data;
  logic          r_ks_valid;
  logic          w_out_free;
  logic          w_gen_step;
  logic          w_gen_fin;

  logic [31:0] w_k0, w_k1, w_k2, w_k3, w_iv0, w_iv1, w_iv2, w_iv3;
  assign w_k0  = r_key[127:96];
  assign w_k1  = r_key[95:64];
  assign w_k2  = r_key[63:32];
  assign w_k3  = r_key[31:0];
  assign w_iv0 = r_iv[127:96];
  assign w_iv1 = r_iv[95:64];
  assign w_iv2 = r_iv[63:32];
  assign w_iv3 = r_iv[31:0];

  // s15 in the top word down to s0 in the bottom word
  assign lfsr_init = {w_k3 ^ w_iv0, w_k2, w_k1, w_k0 ^ w_iv1,
                      w_k3 ^ c_ones, w_k2 ^ c_ones ^ w_iv2, w_k1 ^ c_ones ^ w_iv3, w_k0 ^ c_ones,
                      w_k3, w_k2, w_k1, w_k0,
                      w_k3 ^ c_ones, w_k2 ^ c_ones, w_k1 ^ c_ones, w_k0 ^ c_ones};

  assign w_out_free = !r_ks_valid || ks_ready;
  assign w_gen_step = (r_state == S_GEN) && (r_words_left != 16'd0) && w_out_free;
  assign w_gen_fin  = (r_state == S_GEN) && (r_words_left == 16'd0) && w_out_free;

  assign ks_data    = r_ks_data;
  assign ks_valid   = r_ks_valid;
  assign words_left = r_words_left;
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    lfsr_load      = 1'b0;
    lfsr_step      = 1'b0;
    lfsr_init_mode = 1'b0;
    fsm_clear      = 1'b0;
    fsm_step       = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        lfsr_load   = 1'b1;
        fsm_clear   = 1'b1;
        w_state_nxt = S_INIT;
      end
      S_INIT: begin
        fsm_step       = 1'b1;
        lfsr_step      = 1'b1;
        lfsr_init_mode = 1'b1;
        if (r_init_cnt == 5'd31) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        fsm_step    = 1'b1;
        lfsr_step   = 1'b1;
        w_state_nxt = (r_num_words == 16'd0) ? S_DONE : S_GEN;
      end
      S_GEN: begin
        fsm_step  = w_gen_step;
        lfsr_step = w_gen_step;
        if (w_gen_fin) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Cancel suppresses every strobe so the cipher core is left untouched
    if (abort) begin
      w_state_nxt    = S_IDLE;
      lfsr_load      = 1'b0;
      lfsr_step      = 1'b0;
      lfsr_init_mode = 1'b0;
      fsm_clear      = 1'b0;
      fsm_step       = 1'b0;
      done           = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_iv         <= '0;
      r_num_words  <= '0;
      r_words_left <= '0;
      r_init_cnt   <= '0;
      r_ks_data    <= '0;
      r_ks_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (abort) begin
        r_ks_valid   <= 1'b0;
        r_words_left <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_key        <= key;
            r_iv         <= iv;
            r_num_words  <= num_words;
            r_words_left <= num_words;
          end
          S_LOAD: r_init_cnt <= 5'd0;
          S_INIT: r_init_cnt <= r_init_cnt + 5'd1;
          S_GEN: begin
            if (w_gen_step) begin
              r_ks_data    <= f_word ^ lfsr_s0;
              r_ks_valid   <= 1'b1;
              r_words_left <= r_words_left - 16'd1;
            end else if (r_ks_valid && ks_ready) begin
              r_ks_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snow3g_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_snow3g_ctrl: directed self-checking bench for snow3g_ctrl.          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_snow3g_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic [15:0]  num_words = '0;
  logic [31:0]  f_word = '0;
  logic [31:0]  lfsr_s0 = '0;
  logic [511:0] lfsr_init;
  logic         lfsr_load, lfsr_step, lfsr_init_mode, fsm_clear, fsm_step;
  logic [31:0]  ks_data;
  logic         ks_valid;
  logic         ks_ready = 1'b0;
  logic         busy, done;
  logic [15:0]  words_left;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [511:0] c_zero_img = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

  snow3g_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key(key), .iv(iv), .num_words(num_words),
    .f_word(f_word), .lfsr_s0(lfsr_s0), .lfsr_init(lfsr_init),
    .lfsr_load(lfsr_load), .lfsr_step(lfsr_step), .lfsr_init_mode(lfsr_init_mode),
    .fsm_clear(fsm_clear), .fsm_step(fsm_step),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done), .words_left(words_left)
  );

  always #5 clk = ~clk;

  // Starts a session; returns observations from the edge sampling start
  // until ks_valid (or done) first seen, plus strobe counts along the way.
  task automatic run_session(input logic [15:0] nw, output int lat, output int n_load,
                             output int n_init, output int n_other, output int n_overlap);
    num_words = nw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; n_load = 0; n_init = 0; n_other = 0; n_overlap = 0;
    while (!ks_valid && !done && lat < 100) begin
      if (lfsr_load) n_load++;
      if (lfsr_step && lfsr_init_mode) n_init++;
      if (lfsr_step && !lfsr_init_mode) n_other++;
      if (lfsr_load && lfsr_step) n_overlap++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (busy && g < 200) begin
      g++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || ks_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags busy=%b valid=%b done=%b want 0 0 0", busy, ks_valid, done);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (ks_data !== 32'h0 || words_left !== 16'h0)
      $display("FAIL reset_regs data=%h left=%h want 0 0", ks_data, words_left);
    else pass_cnt++;
    total_cnt++; if ({lfsr_load, lfsr_step, lfsr_init_mode, fsm_clear, fsm_step} !== 5'b0)
      $display("FAIL reset_strobes got=%b want 00000",
               {lfsr_load, lfsr_step, lfsr_init_mode, fsm_clear, fsm_step});
    else pass_cnt++;
    total_cnt++; if (lfsr_init !== c_zero_img)
      $display("FAIL reset_lfsr_init got=%h want %h", lfsr_init, c_zero_img);
    else pass_cnt++;
  endtask

  task automatic test_lfsr_init();
    key = 128'h2BD6459F82C5B300952C49104881FF48;
    iv  = 128'hEA024714AD5C4D84DF1F9B251C0BF45F;
    num_words = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (lfsr_load !== 1'b1 || fsm_clear !== 1'b1 || busy !== 1'b1)
      $display("FAIL load_strobes load=%b clear=%b busy=%b want 1 1 1", lfsr_load, fsm_clear, busy);
    else pass_cnt++;
    total_cnt++; if (lfsr_init[511:480] !== 32'hA283B85C)
      $display("FAIL init_s15 got=%h want A283B85C", lfsr_init[511:480]);
    else pass_cnt++;
    total_cnt++; if (lfsr_init[31:0] !== 32'hD429BA60)
      $display("FAIL init_s0 got=%h want D429BA60", lfsr_init[31:0]);
    else pass_cnt++;
    total_cnt++; if (lfsr_init[351:320] !== 32'hB5CC2DCA)
      $display("FAIL init_s10 got=%h want B5CC2DCA", lfsr_init[351:320]);
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0 || lfsr_step !== 1'b0)
      $display("FAIL abort_after_load busy=%b step=%b want 0 0", busy, lfsr_step);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, nl, ni, no, nov;
    key = '0; iv = '0; ks_ready = 1'b1;
    f_word = 32'h12345678; lfsr_s0 = 32'h0F0F0F0F;
    run_session(16'd2, lat, nl, ni, no, nov);
    total_cnt++; if (lat !== 35)
      $display("FAIL basic_latency got=%0d want 35", lat);
    else pass_cnt++;
    total_cnt++; if (nl !== 1 || ni !== 32 || no !== 2 || nov !== 0)
      $display("FAIL basic_strobes load=%0d init=%0d other=%0d overlap=%0d want 1 32 2 0",
               nl, ni, no, nov);
    else pass_cnt++;
    total_cnt++; if (ks_valid !== 1'b1 || ks_data !== 32'h1D3B5977)
      $display("FAIL basic_word1 valid=%b data=%h want 1 1D3B5977", ks_valid, ks_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ks_valid !== 1'b1 || words_left !== 16'd0)
      $display("FAIL basic_word2 valid=%b left=%0d want 1 0", ks_valid, words_left);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || ks_valid !== 1'b0)
      $display("FAIL basic_done done=%b valid=%b want 1 0", done, ks_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_idle done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int lat, nl, ni, no, nov, n_dlv, g;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hA000FFFE; exp_w[1] = 32'hB000FFFD; exp_w[2] = 32'hB000FFFD;
    ks_ready = 1'b1; f_word = 32'hA0000001; lfsr_s0 = 32'h0000FFFF;
    run_session(16'd3, lat, nl, ni, no, nov);
    ks_ready = 1'b0;
    f_word = 32'hB0000002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++; if (ks_valid !== 1'b1 || ks_data !== 32'hA000FFFE || fsm_step !== 1'b0 ||
                       lfsr_step !== 1'b0 || words_left !== 16'd2)
        $display("FAIL stall_hold_%0d valid=%b data=%h fstep=%b lstep=%b left=%0d want 1 A000FFFE 0 0 2",
                 i, ks_valid, ks_data, fsm_step, lfsr_step, words_left);
      else pass_cnt++;
    end
    ks_ready = 1'b1;
    n_dlv = 0; g = 0;
    while (!done && g < 50) begin
      if (ks_valid && ks_ready) begin
        if (n_dlv < 3) begin
          total_cnt++; if (ks_data !== exp_w[n_dlv])
            $display("FAIL stall_word_%0d got=%h want %h", n_dlv, ks_data, exp_w[n_dlv]);
          else pass_cnt++;
        end
        n_dlv++;
      end
      g++;
      @(negedge clk);
    end
    total_cnt++; if (n_dlv !== 3 || done !== 1'b1)
      $display("FAIL stall_count delivered=%0d done=%b want 3 1", n_dlv, done);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_zero();
    int lat, nl, ni, no, nov;
    ks_ready = 1'b1;
    run_session(16'd0, lat, nl, ni, no, nov);
    total_cnt++; if (lat !== 34 || done !== 1'b1 || ks_valid !== 1'b0)
      $display("FAIL zero_words lat=%0d done=%b valid=%b want 34 1 0", lat, done, ks_valid);
    else pass_cnt++;
    total_cnt++; if (ni !== 32 || no !== 1)
      $display("FAIL zero_steps init=%0d other=%0d want 32 1", ni, no);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_abort();
    int lat, nl, ni, no, nov;
    ks_ready = 1'b1;
    num_words = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    total_cnt++; if (lfsr_init_mode !== 1'b1 || busy !== 1'b1)
      $display("FAIL abort_in_init mode=%b busy=%b want 1 1", lfsr_init_mode, busy);
    else pass_cnt++;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || ks_valid !== 1'b0 || words_left !== 16'd0)
      $display("FAIL abort_state busy=%b done=%b valid=%b left=%0d want 0 0 0 0",
               busy, done, ks_valid, words_left);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_start_ignored busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    run_session(16'd1, lat, nl, ni, no, nov);
    total_cnt++; if (lat !== 35 || ni !== 32)
      $display("FAIL abort_restart lat=%0d init=%0d want 35 32", lat, ni);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    int lat, nl, ni, no, nov;
    key = 128'h0123456789ABCDEF0123456789ABCDEF;
    ks_ready = 1'b1; f_word = 32'h5555AAAA; lfsr_s0 = 32'h0;
    run_session(16'd5, lat, nl, ni, no, nov);
    reset = 1'b1;
    #1;
    total_cnt++; if (ks_valid !== 1'b0 || ks_data !== 32'h0 || busy !== 1'b0 ||
                     done !== 1'b0 || words_left !== 16'd0)
      $display("FAIL midreset_outs valid=%b data=%h busy=%b done=%b left=%0d want 0 0 0 0 0",
               ks_valid, ks_data, busy, done, words_left);
    else pass_cnt++;
    total_cnt++; if (lfsr_init !== c_zero_img)
      $display("FAIL midreset_latched got=%h want %h", lfsr_init, c_zero_img);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_session(16'd1, lat, nl, ni, no, nov);
    total_cnt++; if (lat !== 35 || ks_data !== 32'h5555AAAA)
      $display("FAIL midreset_restart lat=%0d data=%h want 35 5555AAAA", lat, ks_data);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_lfsr_init();
    @(negedge clk);
    test_basic();
    test_stall();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snow3g_ctrl.md
SNOW3G_CTRL -- requirements
Module: snow3g_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL provide: start  in  1  request new session; sampled only in IDLE.
REQ-003 SHALL provide: abort  in  1  synchronous session cancel, any state.
REQ-004 SHALL provide: key  in  128  k0=[127:96] .. k3=[31:0]; iv  in  128  IV0=[127:96] .. IV3=[31:0].
REQ-005 SHALL provide: num_words  in  16  keystream words requested; sampled with start.
REQ-006 SHALL provide: f_word  in  32  FSM output F; lfsr_s0  in  32  current LFSR s0.
REQ-007 SHALL provide: lfsr_init  out  512  LFSR load image, s_i at bits [32i+31:32i].
REQ-008 SHALL provide: lfsr_load  out  1;  lfsr_step  out  1;  lfsr_init_mode  out  1 (feedback XOR F);  fsm_clear  out  1;  fsm_step  out  1.
REQ-009 SHALL provide: ks_data  out  32;  ks_valid  out  1;  ks_ready  in  1.
REQ-010 SHALL provide: busy  out  1;  done  out  1 (one-cycle pulse);  words_left  out  16.

Function
REQ-011 States SHALL be IDLE, LOAD, INIT, DISCARD, GEN, DONE; one-hot or binary at implementer's choice.
REQ-012 IDLE: start=1 SHALL latch key, iv, num_words into internal registers and go to LOAD; start in any other state is ignored.
REQ-013 lfsr_init SHALL be combinational from latched key/iv, 1=32'hFFFFFFFF: s15=k3^IV0, s14=k2, s13=k1, s12=k0^IV1, s11=k3^1, s10=k2^1^IV2, s9=k1^1^IV3, s8=k0^1, s7=k3, s6=k2, s5=k1, s4=k0, s3=k3^1, s2=k2^1, s1=k1^1, s0=k0^1.
REQ-014 LOAD: lfsr_load=1 and fsm_clear=1 for exactly one cycle, then INIT with 5-bit init counter = 0.
REQ-015 INIT: fsm_step=1, lfsr_step=1, lfsr_init_mode=1 every cycle for exactly 32 cycles, then DISCARD.
REQ-016 DISCARD: fsm_step=1, lfsr_step=1, lfsr_init_mode=0 for one cycle; F discarded; next state GEN, or DONE if latched num_words=0.
REQ-017 GEN step condition: words_left>0 and (ks_valid=0 or ks_ready=1); on step, fsm_step=lfsr_step=1, lfsr_init_mode=0, ks_data<=f_word^lfsr_s0, ks_valid<=1, words_left decrements.
REQ-018 GEN without step: ks_valid=1 and ks_ready=1 SHALL clear ks_valid; ks_valid=1 and ks_ready=0 SHALL hold ks_data/ks_valid stable and keep all step outputs low.
REQ-019 GEN SHALL go to DONE when words_left=0 and (ks_valid=0 or ks_ready=1), clearing ks_valid.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Latency: with start sampled at edge E0, first ks_valid=1 SHALL appear after edge E35 (LOAD E1, INIT E2..E33, DISCARD E34, first GEN step E35), given ks_ready held high.
REQ-023 With ks_ready held high, SHALL produce one word per cycle, no bubbles.
REQ-024 abort=1 SHALL force IDLE next edge, clear ks_valid, words_left, all step/load outputs; done not pulsed; abort has priority over start.
REQ-025 words_left SHALL wrap never: no decrement at 0; num_words=16'hFFFF SHALL be supported.
REQ-026 lfsr_load, lfsr_step, fsm_step, fsm_clear SHALL never be high outside the states listed above; lfsr_load and lfsr_step never simultaneously high.

Reset
REQ-027 reset SHALL force IDLE, ks_valid=0, ks_data=0, done=0, busy=0, words_left=0, all latched key/iv/num_words=0, all strobes 0.
REQ-028 reset asserted mid-session SHALL take effect immediately (asynchronously) with the values of REQ-027; no done pulse.

Verification
REQ-029 key=iv=0, num_words=2, ks_ready=1, start one cycle -> lfsr_load one cycle, exactly 32 init-mode steps, 1 discard step, ks_valid high after E35 and E36, done pulse following edge, busy low thereafter.
REQ-030 key=128'h2BD6459F82C5B300952C49104881FF48, iv=128'hEA024714AD5C4D84DF1F9B251C0BF45F -> lfsr_init s15=32'hEA024714^32'h4881FF48 = 32'hA283B85C, s0=~32'h2BD6459F.
REQ-031 num_words=3, ks_ready low 4 cycles after first ks_valid -> ks_data stable, no fsm_step/lfsr_step during stall, 3 words total delivered.
REQ-032 num_words=0 -> DISCARD then DONE directly, ks_valid never high.
REQ-033 abort during INIT cycle 10, then start asserted same cycle -> IDLE, no done, start ignored; next start runs full 32-step INIT.
REQ-034 reset pulse during GEN with ks_valid=1 -> all outputs per REQ-027 within the reset cycle; start afterwards yields normal REQ-022 timing.
